pll_drp_reconfig_ctrl: RTL and testbench
========================================

Name: pll_drp_reconfig_ctrl

Overview:
- Runtime sequencer for the 7-series PLL dynamic reconfiguration port (DRP). Retunes the CLKOUT0 (clk_sys) divider without a bitstream change.
- Accepts a divide request, holds the PLL in reset, read-modify-writes the two CLKOUT0 DRP registers, then releases reset and waits for lock.
- Sits beside the clock generator and is clocked by a free-running, non-PLL clock (buffered IO clock).

Parameters:
- ClkReg1Addr, 7'h08, DRP address of CLKOUT0 ClkReg1 (HIGH_TIME[11:6], LOW_TIME[5:0])
- ClkReg2Addr, 7'h09, DRP address of CLKOUT0 ClkReg2 (EDGE bit 7, NO_COUNT bit 6)
- RstHoldCycles, 16, cycles pll_rst_o is held high before the first DRP access
- DrdyTimeout, 64, maximum cycles to wait for drp_drdy_i per access
- LockTimeout, 65536, maximum cycles to wait for pll_locked_i after reset release
- ResetDiv, 24, CLKOUT0 divide value reported on cur_div_o after reset

Ports:
- clk_i  in  1  free-running controller/DRP clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  reconfiguration request
- req_ready_o  out  1  high only in IDLE
- req_div_i  in  7  requested CLKOUT0 divide; legal range 1..63
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a request completes
- err_o  out  1  sticky error flag; cleared by the next accepted request
- cur_div_o  out  7  last successfully applied divide value
- drp_daddr_o  out  7  DRP address
- drp_den_o  out  1  DRP enable, one-cycle pulse
- drp_dwe_o  out  1  DRP write enable; qualifies drp_den_o
- drp_di_o  out  16  DRP write data
- drp_do_i  in  16  DRP read data
- drp_drdy_i  in  1  DRP access complete
- pll_rst_o  out  1  PLL RST drive
- pll_locked_i  in  1  PLL LOCKED, already synchronised to clk_i

Behaviour:
- Reset values:
  - state=IDLE, req_ready_o=1, busy_o=0, done_o=0, err_o=0.
  - drp_den_o=0, drp_dwe_o=0, drp_daddr_o=0, drp_di_o=0.
  - pll_rst_o=0, cur_div_o=ResetDiv.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o. req_div_i is captured on that edge and err_o is cleared.
  - If the captured value is 0 or above 63: err_o=1 and done_o pulses the next cycle. No DRP access and no PLL reset occur. Return to IDLE.
- Field encoding (D = captured divide):
  - HIGH = D>>1, LOW = D-HIGH.
  - EDGE = D[0], NO_COUNT = (D==1).
  - All fields are zero-extended into their bit positions.
- States and transitions:
  - IDLE -> HOLD_RST: on a valid accept. pll_rst_o=1 and a counter loads RstHoldCycles-1.
  - HOLD_RST: counts down to 0, then -> RD1.
  - RD1: one cycle. den=1, dwe=0, daddr=ClkReg1Addr. -> WAIT_RD1.
  - WAIT_RD1: on drdy, latch {drp_do_i[15:12], LOW/HIGH fields} into the write-data register. -> WR1.
  - WR1: one cycle. den=1, dwe=1, di=latched word. -> WAIT_WR1. On drdy -> RD2.
  - RD2 / WAIT_RD2 / WR2 / WAIT_WR2: same pattern at ClkReg2Addr. Bits [7:6] are replaced; all other bits are preserved.
  - WAIT_WR2: on drdy, pll_rst_o=0 -> WAIT_LOCK.
  - WAIT_LOCK: pll_locked_i high -> DONE.
  - DONE: one cycle. done_o=1, cur_div_o=D. -> IDLE.
- Timeouts (error path):
  - Each WAIT_* state runs a counter. If drdy is absent for DrdyTimeout cycles, or lock is absent for LockTimeout cycles: err_o=1, pll_rst_o=0, go to DONE.
  - On the error path cur_div_o is not updated.
- Boundary cases:
  - drp_drdy_i outside a WAIT_* state is ignored.
  - pll_locked_i is ignored during HOLD_RST..WAIT_WR2. Lock is sampled only in WAIT_LOCK, and lock already high on entry completes the next cycle.
  - req_valid_i while busy is not accepted; it is held off by req_ready_o=0.
  - Reset mid-sequence: outputs return to reset values immediately, including pll_rst_o=0. The PLL may then hold a partially written configuration, which software recovers by issuing a new request.
- Latency, no waits on drdy or lock: 1 + RstHoldCycles + 4×(1+drdy latency) + 1 + 1 cycles from accept to done_o.

Optional Feature:
- PLL_DRP_READBACK_EN defined:
  - After WAIT_WR2, extra states RB1/WAIT_RB1/RB2/WAIT_RB2 re-read both registers with the normal DrdyTimeout.
  - Any mismatch against the written words sets err_o, releases reset and goes to DONE without updating cur_div_o.
  - Reset release then occurs after WAIT_RB2.
- Undefined: the readback states do not exist, and behaviour is exactly as described above.

Test Plan:
- Bench DRP model: drdy 3 cycles after den, ClkReg1=16'hF3CF, ClkReg2=16'h00C0. Request D=10 -> writes ClkReg1=16'hF145, then ClkReg2=16'h0000. Lock asserted 100 cycles after reset release -> done_o pulses once, cur_div_o=10, err_o=0.
- Request D=1 -> ClkReg1 low 12 bits = 12'h001, ClkReg2[7:6]=2'b11.
- Request D=0, then D=64 -> err_o=1 and done_o in the cycle after each accept. pll_rst_o and drp_den_o never assert; cur_div_o unchanged.
- drp_drdy_i never asserted in WAIT_RD1 -> err_o after 64 cycles, pll_rst_o=0, back to IDLE. A following valid request clears err_o.
- rst_i pulsed while in WAIT_WR1 -> pll_rst_o and all DRP outputs 0 in the same cycle. cur_div_o=ResetDiv, req_ready_o=1.
- With PLL_DRP_READBACK_EN: the model corrupts ClkReg2 on write -> err_o=1, cur_div_o unchanged.

Source files
------------

// File: rtl/pll_drp_reconfig_ctrl.sv
// Retunes PLL CLKOUT0 over DRP: holds PLL reset, read-modify-writes ClkReg1/ClkReg2, releases reset, waits for lock.
// One request at a time (req_ready_o only in IDLE); define PLL_DRP_READBACK_EN to verify both registers before reset release.
module pll_drp_reconfig_ctrl #(
   parameter logic [6:0] ClkReg1Addr   = 7'h08,
   parameter logic [6:0] ClkReg2Addr   = 7'h09,
   parameter int         RstHoldCycles = 16,
   parameter int         DrdyTimeout   = 64,
   parameter int         LockTimeout   = 65536,
   parameter logic [6:0] ResetDiv      = 7'd24
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [6:0]  req_div_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [6:0]  cur_div_o,
   output logic [6:0]  drp_daddr_o,
   output logic        drp_den_o,
   output logic        drp_dwe_o,
   output logic [15:0] drp_di_o,
   input  logic [15:0] drp_do_i,
   input  logic        drp_drdy_i,
   output logic        pll_rst_o,
   input  logic        pll_locked_i
);
   localparam int CntW = $clog2(LockTimeout + DrdyTimeout + RstHoldCycles) + 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(RstHoldCycles - 1);
   localparam logic [CntW-1:0] DrdyLast = CntW'(DrdyTimeout - 1);
   localparam logic [CntW-1:0] LockLast = CntW'(LockTimeout - 1);

   typedef enum logic [3:0] {
      IDLE, HOLD_RST, RD1, WAIT_RD1, WR1, WAIT_WR1, RD2, WAIT_RD2, WR2, WAIT_WR2,
`ifdef PLL_DRP_READBACK_EN
      RB1, WAIT_RB1, RB2, WAIT_RB2,
`endif
      WAIT_LOCK, DONE
   } state_t;

   state_t            state_q, state_d, wait_next;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [6:0]        div_q, cur_div_q;
   logic [15:0]       wr1_q, wr2_q, w1_new, w2_new;
   logic [5:0]        f_high, f_low;
   logic              err_q, err_set, pll_rst_q, pll_rst_d;
   logic              accept, div_ok, drp_wait, rb_bad;

   assign accept = req_valid_i && (state_q == IDLE);
   assign div_ok = (req_div_i != 7'd0) && (req_div_i <= 7'd63);

   // Fields are built from the captured divide; upper bits of the read word are preserved
   assign f_high = {1'b0, div_q[5:1]};
   assign f_low  = div_q[5:0] - f_high;
   assign w1_new = {drp_do_i[15:12], f_high, f_low};
   assign w2_new = {drp_do_i[15:8], div_q[0], (div_q == 7'd1), drp_do_i[5:0]};

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign err_o       = err_q;
   assign cur_div_o   = cur_div_q;
   assign pll_rst_o   = pll_rst_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      drp_wait  = 1'b1;
      wait_next = IDLE;
      rb_bad    = 1'b0;
      case (state_q)
         WAIT_RD1: wait_next = WR1;
         WAIT_WR1: wait_next = RD2;
         WAIT_RD2: wait_next = WR2;
`ifdef PLL_DRP_READBACK_EN
         WAIT_WR2: wait_next = RB1;
         WAIT_RB1: begin wait_next = RB2;       rb_bad = (drp_do_i != wr1_q); end
         WAIT_RB2: begin wait_next = WAIT_LOCK; rb_bad = (drp_do_i != wr2_q); end
`else
         WAIT_WR2: wait_next = WAIT_LOCK;
`endif
         default:  drp_wait = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_set     = 1'b0;
      drp_den_o   = 1'b0;
      drp_dwe_o   = 1'b0;
      drp_daddr_o = '0;
      drp_di_o    = '0;
      // Every DRP wait shares one completion/timeout rule; the counter restarts on each exit
      if (drp_wait) begin
         if (drp_drdy_i) begin
            cnt_d = '0;
            if (rb_bad) begin
               err_set = 1'b1;
               state_d = DONE;
            end else begin
               state_d = wait_next;
            end
         end else if (cnt_q == DrdyLast) begin
            err_set = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
      case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = div_ok ? HOLD_RST : DONE;
            cnt_d   = HoldLast;
         end
         HOLD_RST: if (cnt_q == '0) state_d = RD1;
                   else             cnt_d   = cnt_q - CntW'(1);
         RD1: begin
            drp_den_o = 1'b1; drp_daddr_o = ClkReg1Addr; cnt_d = '0; state_d = WAIT_RD1;
         end
         WR1: begin
            drp_den_o = 1'b1; drp_dwe_o = 1'b1; drp_daddr_o = ClkReg1Addr; drp_di_o = wr1_q;
            cnt_d = '0; state_d = WAIT_WR1;
         end
         RD2: begin
            drp_den_o = 1'b1; drp_daddr_o = ClkReg2Addr; cnt_d = '0; state_d = WAIT_RD2;
         end
         WR2: begin
            drp_den_o = 1'b1; drp_dwe_o = 1'b1; drp_daddr_o = ClkReg2Addr; drp_di_o = wr2_q;
            cnt_d = '0; state_d = WAIT_WR2;
         end
`ifdef PLL_DRP_READBACK_EN
         RB1: begin
            drp_den_o = 1'b1; drp_daddr_o = ClkReg1Addr; cnt_d = '0; state_d = WAIT_RB1;
         end
         RB2: begin
            drp_den_o = 1'b1; drp_daddr_o = ClkReg2Addr; cnt_d = '0; state_d = WAIT_RB2;
         end
`endif
         WAIT_LOCK: if (pll_locked_i) begin
            state_d = DONE;
         end else if (cnt_q == LockLast) begin
            err_set = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase
      pll_rst_d = !(state_d inside {IDLE, WAIT_LOCK, DONE});
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         div_q     <= '0;
         wr1_q     <= '0;
         wr2_q     <= '0;
         err_q     <= 1'b0;
         cur_div_q <= ResetDiv;
         pll_rst_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pll_rst_q <= pll_rst_d;
         if (accept) begin
            div_q <= req_div_i;
            err_q <= !div_ok;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
         if (drp_drdy_i && state_q == WAIT_RD1) wr1_q <= w1_new;
         if (drp_drdy_i && state_q == WAIT_RD2) wr2_q <= w2_new;
         if (state_q == DONE && !err_q) cur_div_q <= div_q;
      end
   end
endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Randomized bench for pll_drp_reconfig_ctrl with a DRP/PLL behavioural model and arithmetic expectations.
`timescale 1ns/1ps
module tb_pll_drp_reconfig_ctrl;
`ifdef PLL_DRP_READBACK_EN
   localparam int NAcc = 6;
`else
   localparam int NAcc = 4;
`endif

   logic        clk_i = 1'b0, rst_i = 1'b1, req_valid_i = 1'b0;
   logic [6:0]  req_div_i = '0;
   logic        req_ready_o, busy_o, done_o, err_o, drp_den_o, drp_dwe_o, pll_rst_o;
   logic [6:0]  cur_div_o, drp_daddr_o;
   logic [15:0] drp_di_o;
   logic [15:0] drp_do_i = '0;
   logic        drp_drdy_i = 1'b0, pll_locked_i = 1'b0;

   pll_drp_reconfig_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_div_i(req_div_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .cur_div_o(cur_div_o), .drp_daddr_o(drp_daddr_o), .drp_den_o(drp_den_o),
      .drp_dwe_o(drp_dwe_o), .drp_di_o(drp_di_o), .drp_do_i(drp_do_i),
      .drp_drdy_i(drp_drdy_i), .pll_rst_o(pll_rst_o), .pll_locked_i(pll_locked_i)
   );

   initial forever #5 clk_i = ~clk_i;

   int checks = 0, errors = 0;
   int cyc = 0;
   logic [15:0] drp_mem [0:127];
   int pend = 0, den_cnt = 0, rst_seen = 0, rel_n = 0;
   int acc_cyc = 0, done_cyc = 0, done_cnt = 0;
   logic err_at_done = 1'b0, rst_at_done = 1'b0, released = 1'b0;
   logic [15:0] rd_hold = '0;
   bit drdy_off = 0, corrupt2 = 0, lock_stuck = 0;
   int lock_dly = 0;
   int ld_seq = 0, ld_ack = 0;
   logic [15:0] ld1 = '0, ld2 = '0;
   logic [6:0] exp_cur = 7'd24;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // DRP slave (drdy 3 cycles after den), PLL lock model and event recorder, all at negedge
   initial begin
      for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0;
      forever begin
         @(negedge clk_i);
         if (ld_seq != ld_ack) begin
            drp_mem[8] = ld1;
            drp_mem[9] = ld2;
            ld_ack = ld_seq;
         end
         drp_drdy_i = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !drdy_off) begin
               drp_drdy_i = 1'b1;
               drp_do_i   = rd_hold;
            end
         end
         if (drp_den_o) begin
            den_cnt++;
            rd_hold = drp_mem[drp_daddr_o];
            if (drp_dwe_o)
               drp_mem[drp_daddr_o] = (corrupt2 && drp_daddr_o == 7'h09) ? (drp_di_o ^ 16'h0080) : drp_di_o;
            pend = 3;
         end
         if (pll_rst_o) begin
            rst_seen++;
            released = 1'b1;
            rel_n = 0;
         end
         if (lock_stuck) pll_locked_i = 1'b1;
         else if (pll_rst_o) pll_locked_i = 1'b0;
         else if (released) begin
            pll_locked_i = (rel_n >= lock_dly);
            rel_n++;
         end
         if (req_valid_i && req_ready_o) acc_cyc = cyc;
         if (done_o) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err_o;
            rst_at_done = pll_rst_o;
         end
      end
   end

   task automatic issue(input logic [6:0] d);
      @(posedge clk_i); #1;
      req_valid_i = 1'b1;
      req_div_i   = d;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk_i);
         n++;
      end
      check("done_seen", 32'(done_cnt - d0), 1);
      repeat (3) @(posedge clk_i);
      #1;
      check("done_once", 32'(done_cnt - d0), 1);
   endtask

   task automatic do_valid(input logic [6:0] d, input logic [15:0] r1, input logic [15:0] r2,
                           input bit stuck, input int dly);
      int d0, n0, hi, lo;
      logic [15:0] e1, e2;
      ld1 = r1; ld2 = r2; lock_stuck = stuck; lock_dly = dly;
      ld_seq++;
      repeat (2) @(posedge clk_i);
      d0 = done_cnt; n0 = den_cnt;
      issue(d);
      check("err_clr", 32'(err_o), 0);
      check("busy", 32'(busy_o), 1);
      check("not_ready", 32'(req_ready_o), 0);
      wait_done(d0, 400);
      hi = int'(d) / 2;
      lo = int'(d) - hi;
      e1 = 16'((int'(r1) & 'hF000) + hi * 64 + lo);
      e2 = 16'((int'(r2) & 'hFF3F) + (int'(d) % 2) * 128 + ((d == 7'd1) ? 64 : 0));
      check("latency", 32'(done_cyc - acc_cyc), 32'(1 + 16 + NAcc * 4 + 1 + (stuck ? 0 : dly)));
      check("err_done", 32'(err_at_done), 0);
      check("clkreg1", 32'(drp_mem[8]), 32'(e1));
      check("clkreg2", 32'(drp_mem[9]), 32'(e2));
      check("den_count", 32'(den_cnt - n0), 32'(NAcc));
      exp_cur = d;
      check("cur_div", 32'(cur_div_o), 32'(exp_cur));
      check("pll_rst_idle", 32'(pll_rst_o), 0);
   endtask

   task automatic do_bad(input logic [6:0] d);
      int d0, n0, s0;
      d0 = done_cnt; n0 = den_cnt; s0 = rst_seen;
      issue(d);
      check("bad_err", 32'(err_o), 1);
      wait_done(d0, 20);
      check("bad_latency", 32'(done_cyc - acc_cyc), 1);
      check("bad_den", 32'(den_cnt - n0), 0);
      check("bad_rst", 32'(rst_seen - s0), 0);
      check("bad_cur", 32'(cur_div_o), 32'(exp_cur));
      check("bad_sticky", 32'(err_o), 1);
   endtask

   initial begin
      int d0, n0, n;
      bit found;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", 32'(req_ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_drp", 32'({drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o}), 0);
      check("rst_pll", 32'(pll_rst_o), 0);
      check("rst_cur", 32'(cur_div_o), 24);
      rst_i = 1'b0;

      do_valid(7'd10, 16'hF3CF, 16'h00C0, 0, 100);
      check("d10_reg1", 32'(drp_mem[8]), 32'h0000F145);
      check("d10_reg2", 32'(drp_mem[9]), 32'h00000000);
      do_valid(7'd1, 16'hF3CF, 16'h00C0, 1, 0);
      check("d1_low12", 32'(drp_mem[8] & 16'h0FFF), 32'h001);
      check("d1_bits76", 32'((drp_mem[9] >> 6) & 16'h3), 3);
      for (int i = 0; i < 8; i++)
         do_valid(7'($urandom_range(1, 63)), 16'($urandom), 16'($urandom),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 20)));

      do_bad(7'd0);
      do_bad(7'd64);

      drdy_off = 1;
      d0 = done_cnt; n0 = den_cnt;
      issue(7'd5);
      wait_done(d0, 200);
      drdy_off = 0;
      check("to_err", 32'(err_at_done), 1);
      check("to_rst_at_done", 32'(rst_at_done), 0);
      check("to_latency", 32'(done_cyc - acc_cyc), 1 + 16 + 1 + 64);
      check("to_den", 32'(den_cnt - n0), 1);
      check("to_cur", 32'(cur_div_o), 32'(exp_cur));
      check("to_sticky", 32'(err_o), 1);
      check("to_ready", 32'(req_ready_o), 1);
      do_valid(7'($urandom_range(1, 63)), 16'($urandom), 16'($urandom), 0, 5);

`ifdef PLL_DRP_READBACK_EN
      corrupt2 = 1;
      d0 = done_cnt; n0 = den_cnt;
      issue(7'd12);
      wait_done(d0, 200);
      corrupt2 = 0;
      check("rb_err", 32'(err_at_done), 1);
      check("rb_rst_at_done", 32'(rst_at_done), 0);
      check("rb_latency", 32'(done_cyc - acc_cyc), 1 + 16 + 6 * 4);
      check("rb_den", 32'(den_cnt - n0), 6);
      check("rb_cur", 32'(cur_div_o), 32'(exp_cur));
`endif

      lock_stuck = 0; lock_dly = 3;
      issue(7'd7);
      n = 0; found = 0;
      while (!found && n < 200) begin
         @(posedge clk_i); #1;
         n++;
         if (drp_den_o && drp_dwe_o && drp_daddr_o == 7'h08) found = 1;
      end
      check("wr1_seen", 32'(found), 1);
      @(posedge clk_i); #1;
      check("in_wait_wr1", 32'({busy_o, pll_rst_o, drp_den_o}), 32'b110);
      rst_i = 1'b1;
      #1;
      check("mid_pll_rst", 32'(pll_rst_o), 0);
      check("mid_drp", 32'({drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o}), 0);
      check("mid_cur", 32'(cur_div_o), 24);
      check("mid_ready", 32'(req_ready_o), 1);
      check("mid_err", 32'(err_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_cur = 7'd24;
      repeat (6) @(posedge clk_i);
      #1;
      check("stray_drdy_idle", 32'(busy_o), 0);
      check("stray_cur", 32'(cur_div_o), 24);
      do_valid(7'd33, 16'($urandom), 16'($urandom), 0, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
